// File: rtl/drive_input_ctrl.sv
// drive_input_ctrl: driver-side front end for the vehicle physics block.
// It turns the raw start and gear buttons and the brake-pedal ADC sample into
// engine_on, current_gear and the brake flags. It also enforces the start and
// shift interlocks, using the speed fed back from the physics block.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   btn_start         raw start/stop button (asynchronous)
//   btn_gear_up/down  raw gear buttons (asynchronous); up moves toward D, down toward P
//   adc_brake[7:0]    brake pedal sample, 0 = released
//   speed[7:0]        vehicle speed from the physics block
//   engine_on         high only while the engine FSM is in RUN
//   current_gear[3:0] 3=P 6=R 9=N 12=D
//   is_brake_normal   normal brake band (never high together with is_brake_hard)
//   is_brake_hard     hard brake band
//   shift_reject      1-cycle pulse when an interlock refuses a start or shift request

// Per-button conditioner: 2-FF synchronizer, then a stability counter, then
// a one-shot pulse on the accepted 0->1 transition.
module drive_input_ctrl_btn #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [1:0]  sync;
  logic        db;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      db    <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      // The counter runs only while the synchronized level differs from the
      // accepted level. Any bounce back restarts it.
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        db    <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

module drive_input_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] CRANK_CYCLES    = 24'd500000,
  parameter logic [7:0]  BRAKE_NORM_TH   = 8'd40,
  parameter logic [7:0]  BRAKE_HARD_TH   = 8'd180,
  parameter logic [7:0]  BRAKE_HYST      = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_gear_up,
  input  logic       btn_gear_down,
  input  logic [7:0] adc_brake,
  input  logic [7:0] speed,
  output logic       engine_on,
  output logic [3:0] current_gear,
  output logic       is_brake_normal,
  output logic       is_brake_hard,
  output logic       shift_reject
);
  localparam int NUM_BTN = 3;
  localparam logic [3:0] G_P = 4'd3, G_R = 4'd6, G_N = 4'd9, G_D = 4'd12;

  typedef enum logic [1:0] {S_OFF, S_CRANK, S_RUN} state_t;

  // ---- button conditioning: [0]=start [1]=up [2]=down
  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  assign btn_raw = {btn_gear_down, btn_gear_up, btn_start};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    drive_input_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .pulse(btn_pulse[i])
    );
  end

  logic start_p, up_p, dn_p;
  assign start_p = btn_pulse[0];
  assign up_p    = btn_pulse[1];
  assign dn_p    = btn_pulse[2];

  // ---- brake bands with release hysteresis
  logic nb_q, nb_nx, hard_nx, normal_nx;

  always_comb begin
    hard_nx   = is_brake_hard ? (adc_brake >= BRAKE_HARD_TH - BRAKE_HYST)
                              : (adc_brake >= BRAKE_HARD_TH);
    nb_nx     = nb_q ? (adc_brake >= BRAKE_NORM_TH - BRAKE_HYST)
                     : (adc_brake >= BRAKE_NORM_TH);
    // Hard has priority, so the two flags are mutually exclusive.
    normal_nx = !hard_nx && nb_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nb_q            <= 1'b0;
      is_brake_hard   <= 1'b0;
      is_brake_normal <= 1'b0;
    end else begin
      nb_q            <= nb_nx;
      is_brake_hard   <= hard_nx;
      is_brake_normal <= normal_nx;
    end
  end

  // ---- engine FSM and gear selector
  state_t      state, state_nx;
  logic [23:0] crank_cnt, crank_cnt_nx;
  logic [3:0]  gear_nx;
  logic        rej_nx, brk, spd0;

  assign brk       = is_brake_hard | is_brake_normal;
  assign spd0      = (speed == 8'd0);
  assign engine_on = (state == S_RUN);

  always_comb begin
    state_nx     = state;
    crank_cnt_nx = crank_cnt;
    gear_nx      = current_gear;
    rej_nx       = 1'b0;

    case (state)
      S_OFF: if (start_p) begin
        if (brk && current_gear == G_P) begin
          state_nx     = S_CRANK;
          crank_cnt_nx = '0;
        end else begin
          rej_nx = 1'b1;
        end
      end
      S_CRANK: begin
        if (crank_cnt == CRANK_CYCLES - 24'd1) begin
          state_nx     = S_RUN;
          crank_cnt_nx = '0;
        end else begin
          crank_cnt_nx = crank_cnt + 24'd1;
        end
      end
      S_RUN: if (start_p) begin
        if (spd0 && current_gear == G_P) state_nx = S_OFF;
        else                             rej_nx   = 1'b1;
      end
      default: state_nx = S_OFF;
    endcase

    // Shifts are judged against the pre-edge state, so a start pulse that
    // leaves RUN in this cycle does not suppress a coincident shift.
    if (state == S_RUN) begin
      if (up_p && dn_p) begin
        rej_nx = 1'b1;
      end else if (up_p) begin
        case (current_gear)
          G_P:     if (brk && spd0)   gear_nx = G_R; else rej_nx = 1'b1;
          G_R:                        gear_nx = G_N;
          G_N:     if (brk || !spd0)  gear_nx = G_D; else rej_nx = 1'b1;
          default: gear_nx = current_gear;  // D: top of range
        endcase
      end else if (dn_p) begin
        case (current_gear)
          G_D:                        gear_nx = G_N;
          G_N:     if (brk && spd0)   gear_nx = G_R; else rej_nx = 1'b1;
          G_R:     if (spd0)          gear_nx = G_P; else rej_nx = 1'b1;
          default: gear_nx = current_gear;  // P: bottom of range
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_OFF;
      crank_cnt    <= '0;
      current_gear <= G_P;
      shift_reject <= 1'b0;
    end else begin
      state        <= state_nx;
      crank_cnt    <= crank_cnt_nx;
      current_gear <= gear_nx;
      shift_reject <= rej_nx;
    end
  end
endmodule

// File: tb/tb_drive_input_ctrl.sv
// Directed bench for drive_input_ctrl (DEBOUNCE_CYCLES=4, CRANK_CYCLES=10).
// Start-to-engine_on latency measured from the raw press:
// 2 sync + 4 debounce + 1 pulse cycle + 10 crank cycles = 17 edges.
module tb_drive_input_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_gear_up, btn_gear_down;
  logic [7:0] adc_brake, speed;
  logic       engine_on, is_brake_normal, is_brake_hard, shift_reject;
  logic [3:0] current_gear;

  int checks = 0;
  int errors = 0;
  int rej_cnt = 0;

  drive_input_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .CRANK_CYCLES   (24'd10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start      (btn_start),
    .btn_gear_up    (btn_gear_up),
    .btn_gear_down  (btn_gear_down),
    .adc_brake      (adc_brake),
    .speed          (speed),
    .engine_on      (engine_on),
    .current_gear   (current_gear),
    .is_brake_normal(is_brake_normal),
    .is_brake_hard  (is_brake_hard),
    .shift_reject   (shift_reject)
  );

  always #5 clk = ~clk;

  // Counts shift_reject pulses (high cycles).
  always @(posedge clk) begin
    #1;
    if (shift_reject === 1'b1) rej_cnt++;
  end

  // m: {down, up, start}
  task automatic press(input logic [2:0] m, input int hold);
    @(negedge clk);
    {btn_gear_down, btn_gear_up, btn_start} = m;
    repeat (hold) @(negedge clk);
    {btn_gear_down, btn_gear_up, btn_start} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic start_timed(output int n);
    @(negedge clk);
    btn_start = 1'b1;
    n = 0;
    while (engine_on !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 8) btn_start = 1'b0;
    end
    btn_start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_start = 0; btn_gear_up = 0; btn_gear_down = 0;
    adc_brake = 8'd0; speed = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({engine_on, current_gear, is_brake_normal, is_brake_hard, shift_reject} !== 8'b0_0011_000) begin
      errors++;
      $display("FAIL reset_state: got eng=%b gear=%0d n=%b h=%b rej=%b, want 0 3 0 0 0",
               engine_on, current_gear, is_brake_normal, is_brake_hard, shift_reject);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_no_brake;
    int r0;
    r0 = rej_cnt;
    press(3'b001, 20);
    checks++;
    if (rej_cnt - r0 !== 1) begin
      errors++; $display("FAIL start_no_brake_reject: got %0d pulses, want 1", rej_cnt - r0);
    end
    checks++;
    if (engine_on !== 1'b0) begin
      errors++; $display("FAIL start_no_brake_engine: got %b, want 0", engine_on);
    end
  endtask

  task automatic test_crank_and_upshift;
    int n, r0;
    logic [3:0] exp_g[4];
    exp_g = '{4'd6, 4'd9, 4'd12, 4'd12};
    adc_brake = 8'd60; speed = 8'd0;
    repeat (2) @(negedge clk);
    r0 = rej_cnt;
    start_timed(n);
    checks++;
    if (n !== 17) begin
      errors++; $display("FAIL crank_latency: got %0d cycles, want 17", n);
    end
    for (int i = 0; i < 4; i++) begin
      press(3'b010, 8);
      checks++;
      if (current_gear !== exp_g[i]) begin
        errors++; $display("FAIL upshift_%0d: got gear %0d, want %0d", i, current_gear, exp_g[i]);
      end
    end
    checks++;
    if (rej_cnt - r0 !== 0) begin
      errors++; $display("FAIL upshift_reject: got %0d pulses, want 0", rej_cnt - r0);
    end
  endtask

  task automatic test_moving_interlocks;
    int r0;
    speed = 8'd30; adc_brake = 8'd0;
    repeat (2) @(negedge clk);
    r0 = rej_cnt;
    press(3'b100, 8);
    checks++;
    if (current_gear !== 4'd9 || rej_cnt - r0 !== 0) begin
      errors++; $display("FAIL d_to_n: got gear %0d rej %0d, want 9 0", current_gear, rej_cnt - r0);
    end
    press(3'b100, 8);
    checks++;
    if (current_gear !== 4'd9 || rej_cnt - r0 !== 1) begin
      errors++; $display("FAIL n_to_r_moving: got gear %0d rej %0d, want 9 1", current_gear, rej_cnt - r0);
    end
    press(3'b001, 8);
    checks++;
    if (engine_on !== 1'b1 || rej_cnt - r0 !== 2) begin
      errors++; $display("FAIL stop_moving: got eng %b rej %0d, want 1 2", engine_on, rej_cnt - r0);
    end
  endtask

  task automatic test_brake_sweep;
    logic [7:0] vals[13];
    logic       eh[13];
    logic       en[13];
    vals = '{8'd0, 8'd35, 8'd39, 8'd40, 8'd100, 8'd179, 8'd180, 8'd200, 8'd172, 8'd171, 8'd175, 8'd32, 8'd31};
    eh   = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    en   = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      adc_brake = vals[i];
      @(negedge clk);
      checks++;
      if (is_brake_hard !== eh[i] || is_brake_normal !== en[i]) begin
        errors++;
        $display("FAIL brake_adc_%0d: got hard=%b normal=%b, want %b %b",
                 vals[i], is_brake_hard, is_brake_normal, eh[i], en[i]);
      end
    end
    adc_brake = 8'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_glitch_and_both;
    int r0;
    r0 = rej_cnt;
    press(3'b010, 3);
    checks++;
    if (current_gear !== 4'd9 || rej_cnt - r0 !== 0) begin
      errors++; $display("FAIL glitch: got gear %0d rej %0d, want 9 0", current_gear, rej_cnt - r0);
    end
    press(3'b110, 8);
    checks++;
    if (current_gear !== 4'd9 || rej_cnt - r0 !== 1) begin
      errors++; $display("FAIL up_down_both: got gear %0d rej %0d, want 9 1", current_gear, rej_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_crank;
    int n, r0;
    speed = 8'd0; adc_brake = 8'd60;
    repeat (2) @(negedge clk);
    r0 = rej_cnt;
    press(3'b100, 8);
    press(3'b100, 8);
    press(3'b001, 8);
    checks++;
    if (engine_on !== 1'b0 || current_gear !== 4'd3 || rej_cnt - r0 !== 0) begin
      errors++; $display("FAIL park_and_stop: got eng %b gear %0d rej %0d, want 0 3 0",
                         engine_on, current_gear, rej_cnt - r0);
    end
    // Start a crank, then reset a few cycles into it.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (8) @(negedge clk);
    btn_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (engine_on !== 1'b0 || current_gear !== 4'd3 || is_brake_normal !== 1'b0 || shift_reject !== 1'b0) begin
      errors++; $display("FAIL reset_mid_crank: got eng %b gear %0d n %b rej %b, want 0 3 0 0",
                         engine_on, current_gear, is_brake_normal, shift_reject);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (engine_on !== 1'b0) begin
      errors++; $display("FAIL aborted_crank: got eng %b, want 0", engine_on);
    end
    start_timed(n);
    checks++;
    if (n !== 17) begin
      errors++; $display("FAIL recrank_latency: got %0d cycles, want 17", n);
    end
  endtask

  initial begin
    test_reset();
    test_start_no_brake();
    test_crank_and_upshift();
    test_moving_interlocks();
    test_brake_sweep();
    test_glitch_and_both();
    test_reset_mid_crank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
